// File: rtl/data_processor_stats_pkg.sv
// rtl/data_processor_stats_pkg.sv - shared constants for the stream statistics block
//
// Holds the default stream width, the matching keep width, the popcount result
// width and the default rx FIFO capacity used by data_processor_stats.
package data_processor_stats_pkg;

    localparam int AXIS_DATA_WIDTH_DEF = 256;
    localparam int AXIS_KEEP_WIDTH     = AXIS_DATA_WIDTH_DEF / 8;
    // popcount of a full keep vector needs to represent 0..AXIS_KEEP_WIDTH inclusive
    localparam int POPCNT_WIDTH        = $clog2(AXIS_KEEP_WIDTH + 1);
    localparam int FIFO_DEPTH_DEF      = 512;

endpackage

// File: rtl/data_processor_stats_counter.sv
// rtl/data_processor_stats_counter.sv - two-stage byte/packet accumulator for one stream direction
//
// Module dp_stats_counter.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   clear             single-cycle clear; zeroes counters and drops stage-1 contents
//   tvalid/tready/tlast/tkeep  monitored stream handshake
//   byte_cnt, pkt_cnt accumulated bytes and packets
// Optional build macro: DP_STATS_SATURATE_EN (counters saturate at all-ones).
module dp_stats_counter
    import data_processor_stats_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int KEEP_WIDTH = AXIS_KEEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  tvalid,
    input  logic                  tready,
    input  logic                  tlast,
    input  logic [KEEP_WIDTH-1:0] tkeep,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam int POP_W = $clog2(KEEP_WIDTH + 1);

    logic             beat;
    logic [POP_W-1:0] keep_pop;
    logic             s1_valid;
    logic             s1_last;
    logic [POP_W-1:0] s1_bytes;
    logic [CNT_WIDTH-1:0] byte_next;
    logic [CNT_WIDTH-1:0] pkt_next;

    assign beat = tvalid & tready;

    always_comb begin
        keep_pop = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_pop = keep_pop + POP_W'(tkeep[i]);
        end
    end

    // Stage 1: capture what the accepted beat contributes. Non-accepted cycles
    // register zero bytes so stage 2 never picks up stale keep data.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_bytes <= '0;
        end else begin
            s1_valid <= beat;
            s1_last  <= beat & tlast;
            s1_bytes <= beat ? keep_pop : '0;
        end
    end

`ifdef DP_STATS_SATURATE_EN
    logic [CNT_WIDTH:0] byte_sum;
    logic [CNT_WIDTH:0] pkt_sum;

    // one extra bit catches the carry out; on carry the counter pins at all-ones
    assign byte_sum  = {1'b0, byte_cnt} + (CNT_WIDTH + 1)'(s1_bytes);
    assign pkt_sum   = {1'b0, pkt_cnt} + (CNT_WIDTH + 1)'(s1_last);
    assign byte_next = byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
    assign pkt_next  = pkt_sum[CNT_WIDTH] ? '1 : pkt_sum[CNT_WIDTH-1:0];
`else
    assign byte_next = byte_cnt + CNT_WIDTH'(s1_bytes);
    assign pkt_next  = pkt_cnt + CNT_WIDTH'(s1_last);
`endif

    // Stage 2: accumulate. Clear also wins over a beat sitting in stage 1.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (s1_valid) begin
            byte_cnt <= byte_next;
            pkt_cnt  <= pkt_next;
        end
    end

endmodule

// File: rtl/data_processor_stats.sv
// rtl/data_processor_stats.sv - rx/tx stream statistics and rx FIFO occupancy tracking
//
// Ports:
//   axis_aclk, axis_reset           clock and synchronous active-high reset
//   rx_*/tx_* tvalid/tready/tlast/tkeep  monitored stream handshakes
//   fifo_wr_en, fifo_rd_en          rx FIFO push/pop strobes
//   bus_clear_cnt                   clear pulse from the register controller
//   bus_rx/tx_byte_cnt, bus_rx/tx_pkt_cnt  stream counters
//   bus_rx_fifo_depth(_max)         current and peak FIFO occupancy
//   fifo_depth_err                  sticky underflow/overflow flag
// Optional build macro: DP_STATS_SATURATE_EN (stream counters saturate).
module data_processor_stats
    import data_processor_stats_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH         = FIFO_DEPTH_DEF
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic                            rx_tvalid,
    input  logic                            rx_tready,
    input  logic                            rx_tlast,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  rx_tkeep,
    input  logic                            tx_tvalid,
    input  logic                            tx_tready,
    input  logic                            tx_tlast,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  tx_tkeep,
    input  logic                            fifo_wr_en,
    input  logic                            fifo_rd_en,
    input  logic                            bus_clear_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   bus_rx_byte_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   bus_rx_pkt_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   bus_tx_byte_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   bus_tx_pkt_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   bus_rx_fifo_depth,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   bus_rx_fifo_depth_max,
    output logic                            fifo_depth_err
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] DEPTH_FULL = C_S_AXI_DATA_WIDTH'(FIFO_DEPTH);

    dp_stats_counter #(
        .CNT_WIDTH  (C_S_AXI_DATA_WIDTH),
        .KEEP_WIDTH (KEEP_W)
    ) u_rx_stats (
        .clk      (axis_aclk),
        .reset    (axis_reset),
        .clear    (bus_clear_cnt),
        .tvalid   (rx_tvalid),
        .tready   (rx_tready),
        .tlast    (rx_tlast),
        .tkeep    (rx_tkeep),
        .byte_cnt (bus_rx_byte_cnt),
        .pkt_cnt  (bus_rx_pkt_cnt)
    );

    dp_stats_counter #(
        .CNT_WIDTH  (C_S_AXI_DATA_WIDTH),
        .KEEP_WIDTH (KEEP_W)
    ) u_tx_stats (
        .clk      (axis_aclk),
        .reset    (axis_reset),
        .clear    (bus_clear_cnt),
        .tvalid   (tx_tvalid),
        .tready   (tx_tready),
        .tlast    (tx_tlast),
        .tkeep    (tx_tkeep),
        .byte_cnt (bus_tx_byte_cnt),
        .pkt_cnt  (bus_tx_pkt_cnt)
    );

    logic [C_S_AXI_DATA_WIDTH-1:0] depth;
    logic [C_S_AXI_DATA_WIDTH-1:0] depth_next;
    logic                          depth_err_event;

    // Occupancy tracking; out-of-range strobes are held at the limit and flagged.
    always_comb begin
        depth_next      = depth;
        depth_err_event = 1'b0;
        if (fifo_wr_en && !fifo_rd_en) begin
            if (depth == DEPTH_FULL) begin
                depth_err_event = 1'b1;
            end else begin
                depth_next = depth + 1'b1;
            end
        end else if (fifo_rd_en && !fifo_wr_en) begin
            if (depth == '0) begin
                depth_err_event = 1'b1;
            end else begin
                depth_next = depth - 1'b1;
            end
        end
    end

    // Clear leaves the live occupancy alone; only the peak and the error flag
    // are software statistics. Peak follows the registered depth one cycle late.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            depth                 <= '0;
            bus_rx_fifo_depth_max <= '0;
            fifo_depth_err        <= 1'b0;
        end else begin
            depth <= depth_next;
            if (bus_clear_cnt) begin
                bus_rx_fifo_depth_max <= '0;
                fifo_depth_err        <= 1'b0;
            end else begin
                if (depth > bus_rx_fifo_depth_max) begin
                    bus_rx_fifo_depth_max <= depth;
                end
                if (depth_err_event) begin
                    fifo_depth_err <= 1'b1;
                end
            end
        end
    end

    assign bus_rx_fifo_depth = depth;

endmodule

// File: tb/tb_data_processor_stats.sv
// tb/tb_data_processor_stats.sv - self-checking bench for data_processor_stats
module tb_data_processor_stats;

    localparam int DW = 32;
    localparam int KW = 32;
    localparam int FD = 512;
    localparam int HN = 4096;

    logic axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    logic          axis_reset;
    logic          rx_tvalid, rx_tready, rx_tlast;
    logic [KW-1:0] rx_tkeep;
    logic          tx_tvalid, tx_tready, tx_tlast;
    logic [KW-1:0] tx_tkeep;
    logic          fifo_wr_en, fifo_rd_en, bus_clear_cnt;
    logic [DW-1:0] bus_rx_byte_cnt, bus_rx_pkt_cnt, bus_tx_byte_cnt, bus_tx_pkt_cnt;
    logic [DW-1:0] bus_rx_fifo_depth, bus_rx_fifo_depth_max;
    logic          fifo_depth_err;

    data_processor_stats dut (
        .axis_aclk             (axis_aclk),
        .axis_reset            (axis_reset),
        .rx_tvalid             (rx_tvalid),
        .rx_tready             (rx_tready),
        .rx_tlast              (rx_tlast),
        .rx_tkeep              (rx_tkeep),
        .tx_tvalid             (tx_tvalid),
        .tx_tready             (tx_tready),
        .tx_tlast              (tx_tlast),
        .tx_tkeep              (tx_tkeep),
        .fifo_wr_en            (fifo_wr_en),
        .fifo_rd_en            (fifo_rd_en),
        .bus_clear_cnt         (bus_clear_cnt),
        .bus_rx_byte_cnt       (bus_rx_byte_cnt),
        .bus_rx_pkt_cnt        (bus_rx_pkt_cnt),
        .bus_tx_byte_cnt       (bus_tx_byte_cnt),
        .bus_tx_pkt_cnt        (bus_tx_pkt_cnt),
        .bus_rx_fifo_depth     (bus_rx_fifo_depth),
        .bus_rx_fifo_depth_max (bus_rx_fifo_depth_max),
        .fifo_depth_err        (fifo_depth_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: per-edge history of what the inputs asked for. Expected
    // outputs are recomputed from the history with the counting rules: a beat
    // accepted at edge m shows up after edge m+1, and a clear/reset at edge c
    // drops every beat accepted before edge c+1.
    int unsigned h_rxb [HN];
    int unsigned h_txb [HN];
    bit          h_rxl [HN];
    bit          h_txl [HN];
    int          h_depth [HN];
    bit          h_err [HN];
    int          n  = 0;
    int          lc = 0;
    bit          model_on = 1'b1;

    task automatic record();
        int prev;
        if (n >= HN) begin
            $display("FAIL history: got=%0d exp<%0d", n, HN);
            $fatal(1);
        end
        h_rxb[n] = (rx_tvalid && rx_tready) ? $countones(rx_tkeep) : 0;
        h_txb[n] = (tx_tvalid && tx_tready) ? $countones(tx_tkeep) : 0;
        h_rxl[n] = rx_tvalid && rx_tready && rx_tlast;
        h_txl[n] = tx_tvalid && tx_tready && tx_tlast;
        h_err[n] = 1'b0;
        prev     = (n == 0) ? 0 : h_depth[n-1];
        if (axis_reset) begin
            lc         = n;
            h_depth[n] = 0;
        end else begin
            if (bus_clear_cnt) lc = n;
            h_depth[n] = prev;
            if (fifo_wr_en && !fifo_rd_en) begin
                if (prev == FD) h_err[n] = 1'b1;
                else            h_depth[n] = prev + 1;
            end else if (fifo_rd_en && !fifo_wr_en) begin
                if (prev == 0) h_err[n] = 1'b1;
                else           h_depth[n] = prev - 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_bytes(input bit tx);
        logic [31:0] s = '0;
        for (int m = lc + 1; m <= n - 1; m++) s += tx ? h_txb[m] : h_rxb[m];
        return s;
    endfunction

    function automatic logic [31:0] exp_pkts(input bit tx);
        logic [31:0] s = '0;
        for (int m = lc + 1; m <= n - 1; m++) s += 32'(tx ? h_txl[m] : h_rxl[m]);
        return s;
    endfunction

    function automatic logic [31:0] exp_max();
        int mx = 0;
        for (int m = lc; m <= n - 1; m++) if (h_depth[m] > mx) mx = h_depth[m];
        return 32'(mx);
    endfunction

    function automatic logic [31:0] exp_err();
        for (int m = lc + 1; m <= n; m++) if (h_err[m]) return 32'd1;
        return 32'd0;
    endfunction

    task automatic check_model();
        chk("m_rx_byte",   bus_rx_byte_cnt, exp_bytes(1'b0));
        chk("m_rx_pkt",    bus_rx_pkt_cnt,  exp_pkts(1'b0));
        chk("m_tx_byte",   bus_tx_byte_cnt, exp_bytes(1'b1));
        chk("m_tx_pkt",    bus_tx_pkt_cnt,  exp_pkts(1'b1));
        chk("m_depth",     bus_rx_fifo_depth, 32'(h_depth[n]));
        chk("m_depth_max", bus_rx_fifo_depth_max, exp_max());
        chk("m_err",       32'(fifo_depth_err), exp_err());
    endtask

    // Inputs are set at the falling edge, consumed at the next rising edge,
    // and outputs are sampled at the following falling edge.
    task automatic step();
        @(posedge axis_aclk);
        record();
        @(negedge axis_aclk);
        if (model_on) check_model();
        n++;
    endtask

    task automatic idle();
        rx_tvalid = 0; rx_tready = 0; rx_tlast = 0; rx_tkeep = '0;
        tx_tvalid = 0; tx_tready = 0; tx_tlast = 0; tx_tkeep = '0;
        fifo_wr_en = 0; fifo_rd_en = 0; bus_clear_cnt = 0;
    endtask

    task automatic rx_beat(input logic [KW-1:0] keep, input logic last);
        rx_tvalid = 1; rx_tready = 1; rx_tkeep = keep; rx_tlast = last;
    endtask

    task automatic tx_beat(input logic [KW-1:0] keep, input logic last);
        tx_tvalid = 1; tx_tready = 1; tx_tkeep = keep; tx_tlast = last;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        idle();
        axis_reset = 1;
        step();
        step();
        axis_reset = 0;
        step();
        chk("rst_rx_byte", bus_rx_byte_cnt, 32'd0);
        chk("rst_tx_pkt",  bus_tx_pkt_cnt, 32'd0);
        chk("rst_depth",   bus_rx_fifo_depth, 32'd0);
        chk("rst_err",     32'(fifo_depth_err), 32'd0);

        // single two-beat 64-byte rx packet
        rx_beat(32'hFFFF_FFFF, 1'b0); step();
        rx_beat(32'hFFFF_FFFF, 1'b1); step();
        idle();
        chk("pkt64_lat_byte", bus_rx_byte_cnt, 32'd32);
        chk("pkt64_lat_pkt",  bus_rx_pkt_cnt, 32'd0);
        step();
        chk("pkt64_byte", bus_rx_byte_cnt, 32'd64);
        chk("pkt64_pkt",  bus_rx_pkt_cnt, 32'd1);

        // 10 back-to-back single-beat packets on both directions
        bus_clear_cnt = 1; step(); idle();
        for (int i = 0; i < 10; i++) begin
            rx_beat(32'h0000_FFFF, 1'b1);
            tx_beat(32'h0000_FFFF, 1'b1);
            step();
        end
        idle(); step(); step();
        chk("b2b_rx_byte", bus_rx_byte_cnt, 32'd160);
        chk("b2b_rx_pkt",  bus_rx_pkt_cnt, 32'd10);
        chk("b2b_tx_byte", bus_tx_byte_cnt, 32'd160);
        chk("b2b_tx_pkt",  bus_tx_pkt_cnt, 32'd10);

        // clear coincident with an accepted beat
        bus_clear_cnt = 1;
        rx_beat(32'h1, 1'b1);
        tx_beat(32'h1, 1'b1);
        step(); idle(); step();
        chk("clr_rx_byte", bus_rx_byte_cnt, 32'd0);
        chk("clr_rx_pkt",  bus_rx_pkt_cnt, 32'd0);
        chk("clr_tx_byte", bus_tx_byte_cnt, 32'd0);
        chk("clr_tx_pkt",  bus_tx_pkt_cnt, 32'd0);
        rx_beat(32'h1, 1'b1); step(); idle(); step();
        chk("post_clr_byte", bus_rx_byte_cnt, 32'd1);
        chk("post_clr_pkt",  bus_rx_pkt_cnt, 32'd1);

        // depth sequence: 5 writes, 2 write+read, 3 reads
        axis_reset = 1; step(); axis_reset = 0;
        for (int i = 0; i < 10; i++) begin
            int exp_d;
            idle();
            if (i < 5)      begin fifo_wr_en = 1; exp_d = i + 1; end
            else if (i < 7) begin fifo_wr_en = 1; fifo_rd_en = 1; exp_d = 5; end
            else            begin fifo_rd_en = 1; exp_d = 5 - (i - 6); end
            step();
            chk($sformatf("depth_seq%0d", i), bus_rx_fifo_depth, 32'(exp_d));
        end
        idle(); step();
        chk("depth_seq_max", bus_rx_fifo_depth_max, 32'd5);
        chk("depth_seq_err", 32'(fifo_depth_err), 32'd0);

        // underflow at zero, then overflow past capacity
        axis_reset = 1; step(); axis_reset = 0;
        fifo_rd_en = 1; step(); idle();
        chk("uflow_err",   32'(fifo_depth_err), 32'd1);
        chk("uflow_depth", bus_rx_fifo_depth, 32'd0);
        fifo_wr_en = 1;
        for (int i = 0; i < FD + 1; i++) step();
        idle(); step();
        chk("oflow_depth", bus_rx_fifo_depth, 32'(FD));
        chk("oflow_max",   bus_rx_fifo_depth_max, 32'(FD));
        chk("oflow_err",   32'(fifo_depth_err), 32'd1);
        bus_clear_cnt = 1; step(); idle();
        chk("clr_keeps_depth", bus_rx_fifo_depth, 32'(FD));
        chk("clr_err",         32'(fifo_depth_err), 32'd0);

        // randomized traffic, including clears and resets mid-packet
        for (int i = 0; i < 400; i++) begin
            rx_tvalid  = 1'($urandom_range(0, 1));
            rx_tready  = 1'($urandom_range(0, 1));
            rx_tlast   = 1'($urandom_range(0, 1));
            rx_tkeep   = $urandom;
            tx_tvalid  = 1'($urandom_range(0, 1));
            tx_tready  = 1'($urandom_range(0, 1));
            tx_tlast   = 1'($urandom_range(0, 1));
            tx_tkeep   = $urandom;
            fifo_wr_en = 1'($urandom_range(0, 1));
            fifo_rd_en = 1'($urandom_range(0, 1));
            bus_clear_cnt = ($urandom_range(0, 49) == 0);
            axis_reset    = ($urandom_range(0, 99) == 0);
            step();
        end
        idle(); axis_reset = 0;

        // counter at the top of its range: saturate or wrap
        model_on = 1'b0;
        axis_reset = 1; step(); axis_reset = 0; step();
        force dut.u_rx_stats.byte_cnt = 32'hFFFF_FFF0;
        #1;
        release dut.u_rx_stats.byte_cnt;
        chk("preload", bus_rx_byte_cnt, 32'hFFFF_FFF0);
        rx_beat(32'hFFFF_FFFF, 1'b0); step(); idle(); step();
`ifdef DP_STATS_SATURATE_EN
        chk("top_of_range", bus_rx_byte_cnt, 32'hFFFF_FFFF);
`else
        chk("top_of_range", bus_rx_byte_cnt, 32'h0000_0010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
